// File: rtl/fp16_seq_pkg.sv
// Shared types and FP16 field positions for the operand sequencer.
package fp16_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } seq_state_e;

   localparam int unsigned SIGN_BIT = 15;
   localparam int unsigned EXP_MSB  = 14;
   localparam int unsigned EXP_LSB  = 10;
   localparam int unsigned MAN_MSB  = 9;

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted press.
module pb_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic lcd_reset,
   input  logic pb_raw,
   output logic pb_level,
   output logic pb_press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          differ, accept;

   assign differ = (sync2_q != level_q);
   assign accept = differ && (cnt_q == CntLast);

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (accept) begin
         level_d = sync2_q;
         press_d = sync2_q;  // only the rising edge of the debounced level
      end else if (differ) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge lcd_reset) begin
      if (!lcd_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= pb_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign pb_level = level_q;
   assign pb_press = press_q;

endmodule

// File: rtl/fp16_operand_sequencer.sv
// Operand/result sequencer in front of the combinational FP16 adder: loads A/B
// from the keypad, waits for the adder to settle, then captures the sum into C.
module fp16_operand_sequencer
   import fp16_seq_pkg::*;
#(
   parameter int unsigned WIDTH           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned SETTLE_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             lcd_reset,
   input  logic             pb_load_a,
   input  logic             pb_load_b,
   input  logic             pb_compute,
   input  logic [WIDTH-1:0] key_word,
   input  logic [WIDTH-1:0] sum_in,
   output logic [WIDTH-1:0] a_reg,
   output logic [WIDTH-1:0] b_reg,
   output logic [WIDTH-1:0] c_reg,
   output logic             busy,
   output logic             disp_update
);

   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);

   logic press_a, press_b, press_c;
   logic lvl_a, lvl_b, lvl_c;
   logic unused_levels;

   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load_a (
      .clk      (clk),
      .lcd_reset(lcd_reset),
      .pb_raw   (pb_load_a),
      .pb_level (lvl_a),
      .pb_press (press_a)
   );

   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load_b (
      .clk      (clk),
      .lcd_reset(lcd_reset),
      .pb_raw   (pb_load_b),
      .pb_level (lvl_b),
      .pb_press (press_b)
   );

   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_compute (
      .clk      (clk),
      .lcd_reset(lcd_reset),
      .pb_raw   (pb_compute),
      .pb_level (lvl_c),
      .pb_press (press_c)
   );

   assign unused_levels = lvl_a ^ lvl_b ^ lvl_c;

   seq_state_e       state_q;
   logic [SW-1:0]    settle_q;
   logic [WIDTH-1:0] a_q, b_q, c_q;
   logic             busy_q, disp_q;

   // C is written on the last SETTLE edge so the capture lands SETTLE_CYCLES+1
   // clocks after the compute pulse; CAPTURE is the cycle that shows it.
   always_ff @(posedge clk or negedge lcd_reset) begin
      if (!lcd_reset) begin
         state_q  <= IDLE;
         settle_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         busy_q   <= 1'b0;
         disp_q   <= 1'b0;
      end else begin
         disp_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (press_a) begin
                  a_q    <= key_word;
                  disp_q <= 1'b1;
               end else if (press_b) begin
                  b_q    <= key_word;
                  disp_q <= 1'b1;
               end else if (press_c) begin
                  state_q  <= SETTLE;
                  settle_q <= '0;
                  busy_q   <= 1'b1;
               end
            end
            SETTLE: begin
               if (settle_q == SettleLast) begin
                  c_q     <= sum_in;
                  disp_q  <= 1'b1;
                  state_q <= CAPTURE;
               end else begin
                  settle_q <= settle_q + 1'b1;
               end
            end
            CAPTURE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign a_reg       = a_q;
   assign b_reg       = b_q;
   assign c_reg       = c_q;
   assign busy        = busy_q;
   assign disp_update = disp_q;

endmodule

// File: doc/fp16_operand_sequencer.md
Name: fp16_operand_sequencer

Overview:
Synchronous front end for the half-precision adder datapath. It debounces the LCD-board load/compute push buttons and captures the keypad word into operand A or B. On a compute request it waits a fixed settle interval for the combinational FP16 adder, then latches the adder output into result C. It replaces edge-triggered operand loading driven directly by push buttons with a single-clock design and emits a one-cycle pulse to refresh the LCD.

Parameters:
WIDTH, 16, operand/result word width (FP16: sign[15], exp[14:10], mantissa[9:0])
DEBOUNCE_CYCLES, 500000, cycles a synchronised button level must be stable before acceptance (10 ms at 50 MHz)
SETTLE_CYCLES, 4, cycles between operand freeze and result capture; minimum 1

Ports:
clk  in  1  50 MHz system clock
lcd_reset  in  1  asynchronous active-low reset
pb_load_a  in  1  raw push button, active-high: load A
pb_load_b  in  1  raw push button, active-high: load B
pb_compute  in  1  raw push button, active-high: compute and capture C
key_word  in  WIDTH  keypad entry word, low WIDTH bits of the keypad output bus
sum_in  in  WIDTH  FP16 adder result, combinational from a_reg/b_reg
a_reg  out  WIDTH  operand A, drives adder and LCD line A
b_reg  out  WIDTH  operand B, drives adder and LCD line B
c_reg  out  WIDTH  captured result, drives LCD line C
busy  out  1  high while a compute is in progress
disp_update  out  1  one-cycle pulse when any of a_reg/b_reg/c_reg changes

Behaviour:
- Reset: clk and lcd_reset as above; reset is asynchronous and active-low. While lcd_reset=0: a_reg=b_reg=c_reg=0, busy=0, disp_update=0, FSM=IDLE, debouncers cleared (debounced level 0, counters 0, synchronisers 0). Reset asserted mid-compute aborts the compute; c_reg stays 0.
- Per button: 2-flop synchroniser. The debounce counter increments while the synchronised level differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronised value and the counter clears. A rising edge of the debounced level gives a one-cycle press pulse. Releases produce no pulse. A held button yields exactly one pulse.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE: a load_a pulse sets a_reg<=key_word. A load_b pulse sets b_reg<=key_word. Either one asserts disp_update next cycle. A compute pulse moves to SETTLE, clears the settle counter, and sets busy=1.
  - Priority for same-cycle pulses in IDLE: load_a > load_b > compute. Lower-priority pulses that cycle are dropped, not queued.
  - SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE. Operands stay frozen.
  - CAPTURE: c_reg<=sum_in, disp_update=1 for this one cycle, busy=0 next cycle, return to IDLE.
- Load and compute pulses arriving while busy=1 are ignored (dropped).
- Latency: from the compute pulse (IDLE) to the c_reg update is SETTLE_CYCLES+1 clocks. From a load pulse, register update and disp_update are on the next edge.
- No arithmetic is performed; sum_in is captured verbatim. key_word is captured verbatim with no range or NaN checks.
- disp_update never asserts during reset and never for two consecutive cycles from one event.

Decomposition:
- Package fp16_seq_pkg: state enum (IDLE, SETTLE, CAPTURE); FP16 field constants (SIGN_BIT=15, EXP_MSB=14, EXP_LSB=10, MAN_MSB=9).
- Sub-module pb_debounce (param DEBOUNCE_CYCLES; ports clk, lcd_reset, pb_raw, pb_level, pb_press), instantiated three times.
- Top holds the FSM, settle counter and operand/result registers.

Test Plan:
- Sim params DEBOUNCE_CYCLES=4, SETTLE_CYCLES=4. Hold lcd_reset=0 -> all outputs 0. Release, key_word=16'h3C00, press pb_load_a 10 cycles -> a_reg=16'h3C00 exactly once, one disp_update pulse, b_reg/c_reg unchanged.
- Bounce pb_load_b 1-0-1-0 at 1-cycle spacing, then hold high 10 cycles with key_word=16'h4000 -> a single b_reg=16'h4000 update, one disp_update.
- a_reg=16'h3C00, b_reg=16'h4000, bench adder model drives sum_in=16'h4200; press pb_compute -> busy high for 5 cycles, c_reg=16'h4200 on cycle 5 after the press pulse, disp_update coincident with the capture.
- During SETTLE, press pb_load_a with key_word=16'hFFFF -> a_reg unchanged, c_reg=16'h4200.
- Force debounced press pulses of load_a and compute in the same cycle -> a_reg loads, busy stays 0, no compute.
- Assert lcd_reset during SETTLE -> all registers 0 immediately (asynchronous), FSM IDLE, no capture after release.
